scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clk cycles per scan tick (legal range 3..65535).
REQ-002 SHALL have parameter DWELL, default 2, meaning ticks held at each end before reversing (legal range 0..255).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  level; 1 = scan active, 0 = stop.
REQ-006 SHALL have port count  input  4  position returned by the saturating 0..7 position counter.
REQ-007 SHALL have port enable  output  1  one-cycle step request to the position counter.
REQ-008 SHALL have port dir  output  1  step direction to the counter; 0 = up, 1 = down.
REQ-009 SHALL have port leds  output  8  LED bar, bit i lit for position i.
REQ-010 SHALL have port end_pulse  output  1  one-cycle pulse on reaching either end.

Function
REQ-011 Prescaler SHALL count 0..DIV-1 while run=1; tick = prescaler at DIV-1; prescaler SHALL clear to 0 whenever run=0.
REQ-012 FSM SHALL have states IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
REQ-013 IDLE -> UP on first cycle run=1; any state -> IDLE on next edge when run=0.
REQ-014 UP, on tick: if count>=7 -> DWELL_HI (DWELL>0) or DOWN (DWELL=0), no enable; else assert enable.
REQ-015 DOWN, on tick: if count==0 -> DWELL_LO (DWELL>0) or UP (DWELL=0), no enable; else assert enable.
REQ-016 DWELL_HI/DWELL_LO SHALL count ticks; on the DWELL-th tick -> DOWN/UP respectively, no enable during dwell.
REQ-017 enable SHALL be registered: high exactly the cycle after the qualifying tick, for one cycle; never two enables closer than DIV cycles.
REQ-018 dir SHALL be registered: 0 in IDLE, UP, DWELL_LO; 1 in DOWN, DWELL_HI; dir SHALL be stable in every cycle enable=1.
REQ-019 end_pulse SHALL be high one cycle, the cycle after the end-detect tick (same cycle enable would have been).
REQ-020 leds SHALL be registered, 1-cycle latency from count: one-hot of count[2:0] for count<=7, 8'h00 for count>=8 or in IDLE.
REQ-021 count values 8..15 SHALL be treated as upper end in UP and as non-zero in DOWN.
REQ-022 run toggled 0 then 1 SHALL restart from UP with prescaler at 0, regardless of count.

Reset
REQ-023 On reset=1 at a clk edge: state=IDLE, prescaler=0, dwell counter=0, enable=0, dir=0, leds=8'h00, end_pulse=0.
REQ-024 reset SHALL dominate run and any in-progress tick or dwell; first possible enable is DIV cycles after reset release with run=1.

Configuration
REQ-025 Macro SCAN_CTRL_TRAIL_EN SHALL, when defined, add a trail register holding the previous position; leds = one-hot(count) OR one-hot(previous) while in UP/DOWN, single LED during dwell, trail cleared by reset, IDLE and on entry to dwell.
REQ-026 Without SCAN_CTRL_TRAIL_EN, leds SHALL be strictly one-hot or zero per REQ-020 and no trail register SHALL exist.

Verification (DIV=4, DWELL=2, counter model attached)
REQ-027 Reset, run=1 held, count=0 -> first enable 4 cycles after reset release with dir=0; next enables every 4 cycles; leds 01,02,04,... 1 cycle after count.
REQ-028 count reaches 7 in UP -> next tick gives end_pulse, no enable, dir=1; enables resume after 2 further ticks; count descends 6..0.
REQ-029 count reaches 0 in DOWN -> end_pulse, 2-tick dwell, dir=0, ascent restarts; full bounce period = 14 steps + 2 end ticks + 4 dwell ticks = 20 ticks = 80 cycles.
REQ-030 run dropped mid-DOWN at count=4 -> enable=0 next cycle, dir=0, leds=00; run reasserted -> UP from count=4, first enable 4 cycles later.
REQ-031 reset asserted during DWELL_HI -> all outputs reset values next edge; forced count=9 in UP -> immediate dwell, leds=00.
REQ-032 With SCAN_CTRL_TRAIL_EN, count 2->3 in UP -> leds=0x0C; at dwell entry leds=0x80 only; without macro leds=0x08.

Source files
------------

// File: rtl/scan_ctrl.sv
// Back-and-forth LED scanner: paces a saturating 0..7 position counter up and down with a dwell at each end.
// Optional SCAN_CTRL_TRAIL_EN adds a one-position trail LED while the scanner is moving.
module scan_ctrl #(
    parameter int DIV   = 4,
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] count,
    output logic       enable,
    output logic       dir,
    output logic [7:0] leds,
    output logic       end_pulse
);

    localparam int             PW         = $clog2(DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam bit             HAS_DWELL  = (DWELL > 0);
    localparam logic [7:0]     DW_LAST    = (DWELL > 0) ? 8'(DWELL - 1) : 8'd0;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        DWELL_HI,
        DOWN,
        DWELL_LO
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    dwell_cnt;
    logic          tick;
    logic          end_hit;

    function automatic logic [7:0] onehot(input logic [3:0] v);
        onehot = v[3] ? 8'h00 : (8'h01 << v[2:0]);
    endfunction

    // Positions 8..15 count as past the top end going up and as non-zero going down.
    assign tick    = run && (presc == PRESC_LAST);
    assign end_hit = tick && (((state == UP) && (count >= 4'd7)) ||
                              ((state == DOWN) && (count == 4'd0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            dwell_cnt <= 8'd0;
            enable    <= 1'b0;
            dir       <= 1'b0;
            end_pulse <= 1'b0;
        end else begin
            enable    <= 1'b0;
            end_pulse <= 1'b0;
            if (!run) begin
                state     <= IDLE;
                presc     <= '0;
                dwell_cnt <= 8'd0;
                dir       <= 1'b0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                case (state)
                    IDLE: begin
                        state <= UP;
                        dir   <= 1'b0;
                    end
                    UP: begin
                        if (end_hit) begin
                            end_pulse <= 1'b1;
                            dwell_cnt <= 8'd0;
                            dir       <= 1'b1;
                            state     <= HAS_DWELL ? DWELL_HI : DOWN;
                        end else if (tick) begin
                            enable <= 1'b1;
                        end
                    end
                    DWELL_HI: begin
                        if (tick) begin
                            if (dwell_cnt == DW_LAST) begin
                                dwell_cnt <= 8'd0;
                                state     <= DOWN;
                            end else begin
                                dwell_cnt <= dwell_cnt + 8'd1;
                            end
                        end
                    end
                    DOWN: begin
                        if (end_hit) begin
                            end_pulse <= 1'b1;
                            dwell_cnt <= 8'd0;
                            dir       <= 1'b0;
                            state     <= HAS_DWELL ? DWELL_LO : UP;
                        end else if (tick) begin
                            enable <= 1'b1;
                        end
                    end
                    DWELL_LO: begin
                        if (tick) begin
                            if (dwell_cnt == DW_LAST) begin
                                dwell_cnt <= 8'd0;
                                state     <= UP;
                            end else begin
                                dwell_cnt <= dwell_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        dwell_cnt <= 8'd0;
                        dir       <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SCAN_CTRL_TRAIL_EN
    logic [3:0] pos_q;
    logic [3:0] trail_q;
    logic       trail_vld;
    logic       dwell_entry;
    logic       moving;
    logic       capture;
    logic       trail_show;
    logic [3:0] trail_sel;

    // The trail is the last distinct position seen while moving; it is dropped when a dwell begins.
    assign dwell_entry = end_hit && HAS_DWELL;
    assign moving      = run && ((state == IDLE) || (state == UP) || (state == DOWN)) && !dwell_entry;
    assign capture     = ((state == UP) || (state == DOWN)) && (count != pos_q) && !dwell_entry;
    assign trail_sel   = capture ? pos_q : trail_q;
    assign trail_show  = moving && (capture || trail_vld);

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q     <= 4'd0;
            trail_q   <= 4'd0;
            trail_vld <= 1'b0;
            leds      <= 8'h00;
        end else begin
            pos_q <= count;
            if (!run || dwell_entry || (state == IDLE)) begin
                trail_vld <= 1'b0;
            end else if (capture) begin
                trail_q   <= pos_q;
                trail_vld <= 1'b1;
            end
            if (!run) begin
                leds <= 8'h00;
            end else begin
                leds <= onehot(count) | (trail_show ? onehot(trail_sel) : 8'h00);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            leds <= 8'h00;
        end else if (!run) begin
            leds <= 8'h00;
        end else begin
            leds <= onehot(count);
        end
    end
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl (default build, DIV=4, DWELL=2) with a saturating position counter attached.
module tb_scan_ctrl;

    localparam int DIV   = 4;
    localparam int DWELL = 2;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] count;
    logic       enable;
    logic       dir;
    logic [7:0] leds;
    logic       end_pulse;

    typedef struct {
        logic       en;
        logic       dr;
        logic [7:0] ld;
        logic       ep;
    } exp_t;

    exp_t sbq[$];
    int   epq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   lastEn = -1;
    int   mMode = 0;
    int   mPre = 0;
    int   mDw = 0;
    bit   hold = 0;
    logic prevEn = 0;
    logic prevDir = 0;
    bit   found;

    scan_ctrl #(.DIV(DIV), .DWELL(DWELL)) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .count(count),
        .enable(enable),
        .dir(dir),
        .leds(leds),
        .end_pulse(end_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: mode 0 idle, 1 up, 2 dwell high, 3 down, 4 dwell low.
    task automatic applyStimulus();
        exp_t e;
        bit   tk;
        e.en = 1'b0;
        e.ep = 1'b0;
        e.ld = 8'h00;
        if (reset || !run) begin
            mMode = 0;
            mPre  = 0;
            mDw   = 0;
        end else begin
            tk   = (mPre == DIV - 1);
            mPre = tk ? 0 : mPre + 1;
            e.ld = (count < 8) ? 8'(1 << count) : 8'h00;
            if (mMode == 0) begin
                mMode = 1;
            end else if (tk) begin
                case (mMode)
                    1: if (count >= 7) begin e.ep = 1'b1; mMode = (DWELL > 0) ? 2 : 3; end
                       else e.en = 1'b1;
                    2: begin mDw++; if (mDw == DWELL) begin mDw = 0; mMode = 3; end end
                    3: if (count == 0) begin e.ep = 1'b1; mMode = (DWELL > 0) ? 4 : 1; end
                       else e.en = 1'b1;
                    4: begin mDw++; if (mDw == DWELL) begin mDw = 0; mMode = 1; end end
                    default: mMode = 0;
                endcase
            end
        end
        e.dr = (mMode == 2) || (mMode == 3);
        sbq.push_back(e);
    endtask

    // One clock: predict, clock, compare, then advance the attached counter as hardware would.
    task automatic cycle();
        exp_t e;
        applyStimulus();
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checkOutput("enable", {31'd0, enable}, {31'd0, e.en});
        checkOutput("dir", {31'd0, dir}, {31'd0, e.dr});
        checkOutput("leds", {24'd0, leds}, {24'd0, e.ld});
        checkOutput("end_pulse", {31'd0, end_pulse}, {31'd0, e.ep});
        if (enable) begin
            if (lastEn >= 0) checkOutput("enGapAtLeastDiv", {31'd0, (cyc - lastEn) >= DIV}, 32'd1);
            lastEn = cyc;
        end
        if (end_pulse) epq.push_back(cyc);
        if (!hold && prevEn) begin
            if (!prevDir && count < 4'd7) count = count + 4'd1;
            else if (prevDir && count > 4'd0) count = count - 4'd1;
        end
        prevEn  = enable;
        prevDir = dir;
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        count = 4'd0;
        repeat (3) cycle();
        checkOutput("rstEnable", {31'd0, enable}, 32'd0);
        checkOutput("rstDir", {31'd0, dir}, 32'd0);
        checkOutput("rstLeds", {24'd0, leds}, 32'd0);
        checkOutput("rstEndPulse", {31'd0, end_pulse}, 32'd0);

        // Free-running bounce from position 0
        reset = 1'b0;
        run   = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            if (i < 4) checkOutput("preFirstEn", {31'd0, enable}, 32'd0);
        end
        checkOutput("firstEn", {31'd0, enable}, 32'd1);
        checkOutput("firstDir", {31'd0, dir}, 32'd0);
        epq.delete();
        repeat (200) cycle();
        checkOutput("endPulseCount", {31'd0, epq.size() >= 4}, 32'd1);
        for (int i = 1; i < epq.size(); i++) checkOutput("endGap", epq[i] - epq[i-1], 32'd40);
        if (epq.size() >= 3) checkOutput("bouncePeriod", epq[2] - epq[0], 32'd80);

        // Drop run mid-descent at position 4, then resume
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (dir && count == 4'd4) found = 1;
        end
        checkOutput("reachDown4", {31'd0, found}, 32'd1);
        run = 1'b0;
        cycle();
        checkOutput("dropEnable", {31'd0, enable}, 32'd0);
        checkOutput("dropDir", {31'd0, dir}, 32'd0);
        checkOutput("dropLeds", {24'd0, leds}, 32'd0);
        run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            if (i < 4) checkOutput("resumePreEn", {31'd0, enable}, 32'd0);
        end
        checkOutput("resumeEn", {31'd0, enable}, 32'd1);
        checkOutput("resumeDir", {31'd0, dir}, 32'd0);

        // Reset in the middle of the top dwell
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (end_pulse && dir) found = 1;
        end
        checkOutput("reachTopEnd", {31'd0, found}, 32'd1);
        cycle();
        reset = 1'b1;
        cycle();
        checkOutput("dwellRstEnable", {31'd0, enable}, 32'd0);
        checkOutput("dwellRstDir", {31'd0, dir}, 32'd0);
        checkOutput("dwellRstLeds", {24'd0, leds}, 32'd0);
        checkOutput("dwellRstEndPulse", {31'd0, end_pulse}, 32'd0);
        reset = 1'b0;
        repeat (4) cycle();
        checkOutput("postRstEndPulse", {31'd0, end_pulse}, 32'd1);
        checkOutput("postRstEnable", {31'd0, enable}, 32'd0);

        // Out-of-range position treated as the top end
        hold  = 1;
        count = 4'd9;
        run   = 1'b0;
        cycle();
        run = 1'b1;
        repeat (4) cycle();
        checkOutput("cnt9EndPulse", {31'd0, end_pulse}, 32'd1);
        checkOutput("cnt9Enable", {31'd0, enable}, 32'd0);
        checkOutput("cnt9Dir", {31'd0, dir}, 32'd1);
        checkOutput("cnt9Leds", {24'd0, leds}, 32'd0);

        // Step 2 -> 3 shows a single LED in the default build
        count = 4'd2;
        run   = 1'b0;
        cycle();
        run  = 1'b1;
        hold = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (count == 4'd3) found = 1;
        end
        checkOutput("reachCount3", {31'd0, found}, 32'd1);
        cycle();
        checkOutput("leds3", {24'd0, leds}, 32'h08);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
